// File: rtl/key_sched_ctrl.sv
// AES-128 key-schedule controller: sequences an external gen_key round function and holds rk[0..10].
// Optional KEY_ZEROIZE_EN adds a zeroize input that wipes all key material and returns to IDLE.
module key_sched_ctrl #(
  parameter int GK_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
`ifdef KEY_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic [3:0]   gk_round,
  output logic [127:0] gk_key_in,
  input  logic [127:0] gk_key_out,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key,
  output logic         busy,
  output logic         done
);

  localparam int CNT_W = ($clog2(GK_LATENCY + 1) > 4) ? $clog2(GK_LATENCY + 1) : 4;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(GK_LATENCY);
  localparam logic [3:0]       LAST_ROUND = 4'd9;
  localparam logic [3:0]       LAST_ADDR  = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               wipe;
  logic               accept;
  logic               capture;
  logic [CNT_W-1:0]   cnt;
  logic [127:0]       rk [0:10];

`ifdef KEY_ZEROIZE_EN
  assign wipe = zeroize;
`else
  assign wipe = 1'b0;
`endif

  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign capture = (state == WAIT) && (cnt == CNT_LAST);
  assign busy    = (state == WAIT);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (wipe) begin
      state_nxt = IDLE;
    end else if (accept) begin
      state_nxt = WAIT;
    end else if (capture && (gk_round == LAST_ROUND)) begin
      state_nxt = DONE;
    end
  end

  // gen_key inputs stay frozen for GK_LATENCY edges; the following edge captures its result.
  always_ff @(posedge clk) begin
    if (rst || wipe) begin
      for (int i = 0; i < 11; i++) begin
        rk[i] <= '0;
      end
      gk_key_in <= '0;
      gk_round  <= '0;
      cnt       <= '0;
      rd_key    <= '0;
    end else begin
      if (rd_addr <= LAST_ADDR) begin
        rd_key <= rk[rd_addr];
      end else begin
        rd_key <= '0;
      end

      if (accept) begin
        rk[0]     <= cipher_key;
        gk_key_in <= cipher_key;
        gk_round  <= '0;
        cnt       <= '0;
      end else if (state == WAIT) begin
        if (capture) begin
          rk[gk_round + 4'd1] <= gk_key_out;
          gk_key_in           <= gk_key_out;
          cnt                 <= '0;
          gk_round            <= (gk_round == LAST_ROUND) ? 4'd0 : gk_round + 4'd1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: behavioural gen_key plus word-level AES-128 key-expansion reference,
// read scoreboard and per-cycle status checks. Build with KEY_ZEROIZE_EN to exercise zeroize.
module tb_key_sched_ctrl;

  localparam int L       = 2;
  localparam int R       = L + 1;
  localparam int DONE_AT = 10 * R;
  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] cipher_key = '0;
  logic [3:0]   gk_round;
  logic [127:0] gk_key_in;
  logic [127:0] gk_key_out;
  logic [3:0]   rd_addr = '0;
  logic [127:0] rd_key;
  logic         busy;
  logic         done;
`ifdef KEY_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  always #5 clk = ~clk;

  key_sched_ctrl #(.GK_LATENCY(L)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef KEY_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .start     (start),
    .cipher_key(cipher_key),
    .gk_round  (gk_round),
    .gk_key_in (gk_key_in),
    .gk_key_out(gk_key_out),
    .rd_addr   (rd_addr),
    .rd_key    (rd_key),
    .busy      (busy),
    .done      (done)
  );

  // AES helpers
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] p = x;
    for (int k = 1; k < 8; k++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int idx);
    logic [7:0] rc = 8'h01;
    for (int j = 0; j < idx; j++) rc = xt(rc);
    return rc;
  endfunction

  // gen_key round function as the attached block would compute it
  function automatic logic [127:0] gk_fn(input logic [127:0] k, input logic [3:0] rnd);
    logic [31:0] t, w4, w5, w6, w7;
    t  = subword({k[23:0], k[31:24]}) ^ {rcon(int'(rnd)), 24'h0};
    w4 = k[127:96] ^ t;
    w5 = k[95:64] ^ w4;
    w6 = k[63:32] ^ w5;
    w7 = k[31:0] ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  logic [127:0] gk_pipe [L];
  always @(posedge clk) begin
    gk_pipe[0] <= gk_fn(gk_key_in, gk_round);
    for (int j = 1; j < L; j++) gk_pipe[j] <= gk_pipe[j-1];
  end
  assign gk_key_out = gk_pipe[L-1];

  // Reference model state
  logic [127:0] old_ks [11];
  logic [127:0] new_ks [11];
  bit           active = 1'b0;
  int           s_edge = 0;
  int           cyc = 0;
  bit           rd_req = 1'b0;
  bit           rd_vld = 1'b0;
  logic [127:0] want_q [$];
  int           addr_q [$];
  int           n_chk = 0;
  int           n_fail = 0;

  // FIPS-197 word-oriented expansion
  function automatic void expand_into(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = subword({t[23:0], t[31:24]}) ^ {rcon(i/4 - 1), 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) new_ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic bit m_busy(input int c);
    return active && ((c - s_edge) < DONE_AT);
  endfunction

  // Value returned by a read sampled at edge e: entry i is rewritten on edge s_edge + i*R
  function automatic logic [127:0] predict(input int i, input int e);
    if (i > 10) return '0;
    if (active && (e > s_edge + i * R)) return new_ks[i];
    return old_ks[i];
  endfunction

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, want);
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) old_ks[i] = '0;
      active = 1'b0;
`ifdef KEY_ZEROIZE_EN
    end else if (zeroize) begin
      for (int i = 0; i < 11; i++) old_ks[i] = '0;
      active = 1'b0;
`endif
    end else if (start && !m_busy(cyc)) begin
      if (active) old_ks = new_ks;
      expand_into(cipher_key);
      s_edge = cyc + 1;
      active = 1'b1;
    end
    cyc    = cyc + 1;
    rd_vld = rd_req;
  end

  // Monitor: read scoreboard and per-cycle status against the model
  always @(negedge clk) begin
    int k;
    logic [127:0] want;
    if (rd_vld) begin
      if (want_q.size() == 0) begin
        chk("sb_underflow", 128'd1, 128'd0);
      end else begin
        want = want_q.pop_front();
        chk($sformatf("rd_key[%0d]", addr_q.pop_front()), rd_key, want);
      end
    end
    if (cyc > 0) begin
      k = (cyc - s_edge) / R;
      chk("busy", 128'(busy), 128'(m_busy(cyc)));
      chk("done", 128'(done), 128'(active && !m_busy(cyc)));
      chk("gk_round", 128'(gk_round), m_busy(cyc) ? 128'(k) : 128'd0);
      if (!active) chk("gk_key_in", gk_key_in, '0);
      else if (m_busy(cyc)) chk("gk_key_in", gk_key_in, new_ks[k]);
      else chk("gk_key_in", gk_key_in, new_ks[10]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    start      = 1'b1;
    cipher_key = k;
    tick();
    start      = 1'b0;
  endtask

  task automatic rd_exp(input int a, input logic [127:0] want);
    rd_addr = 4'(a);
    rd_req  = 1'b1;
    want_q.push_back(want);
    addr_q.push_back(a);
    tick();
    rd_req  = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_exp(a, predict(a, cyc + 1));
  endtask

  task automatic wait_done();
    for (int i = 0; i < DONE_AT + 10 && !done; i++) tick();
    chk("done_wait", 128'(done), 128'd1);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    for (int a = 0; a < 16; a++) rd(a);

    // FIPS-197 vector, reads while the first expansion runs
    do_start(FIPS_KEY);
    repeat (4) rd($urandom_range(0, 10));
    wait_done();
    rd_exp(1, FIPS_RK1);
    rd_exp(10, FIPS_RK10);
    rd_exp(0, FIPS_KEY);
    rd(11);
    rd(15);

    // Restart from DONE; reads see a mix of old and new entries
    do_start(rand128());
    for (int i = 0; i < 20; i++) rd($urandom_range(0, 10));
    wait_done();
    for (int a = 0; a < 11; a++) rd(a);

    // start while busy is ignored
    do_start(FIPS_KEY);
    repeat (11) tick();
    do_start(rand128());
    wait_done();
    rd_exp(10, FIPS_RK10);

    // reset mid-expansion, then a clean run
    do_start(rand128());
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int a = 0; a < 11; a++) rd(a);
    do_start(rand128());
    wait_done();
    for (int a = 0; a < 11; a++) rd(a);

    // randomized runs with optional spurious starts
    for (int it = 0; it < 6; it++) begin
      do_start(rand128());
      repeat ($urandom_range(0, 8)) rd($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_start(rand128());
      wait_done();
      repeat (4) rd($urandom_range(0, 15));
    end

`ifdef KEY_ZEROIZE_EN
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    for (int a = 0; a < 11; a++) rd(a);
    do_start(rand128());
    wait_done();
    zeroize    = 1'b1;
    start      = 1'b1;
    cipher_key = rand128();
    tick();
    zeroize    = 1'b0;
    start      = 1'b0;
    tick();
    for (int a = 0; a < 11; a++) rd(a);
`endif

    repeat (2) tick();
    chk("sb_leftover", 128'(want_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_sched_ctrl.md
KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 Parameter GK_LATENCY, default 2, SHALL be the clock edges from gen_key inputs (gk_key_in, gk_round) becoming stable to gk_key_out becoming valid.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 start  input  1  SHALL request expansion of cipher_key when high; a single-cycle pulse.
REQ-005 cipher_key  input  128  SHALL be the AES-128 cipher key, sampled on the accepted start edge.
REQ-006 gk_round  output  4  SHALL drive gen_key round (rcon index).
REQ-007 gk_key_in  output  128  SHALL drive gen_key key_in (previous round key).
REQ-008 gk_key_out  input  128  SHALL be gen_key key_out (next round key).
REQ-009 rd_addr  input  4  SHALL be the round-key store read index, 0..10.
REQ-010 rd_key  output  128  SHALL be the registered round key at rd_addr.
REQ-011 busy  output  1  SHALL be high while expansion is in progress.
REQ-012 done  output  1  SHALL be a level, high once all 11 round keys are stored, until the next accepted start or reset.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and DONE; start SHALL be accepted only in IDLE or DONE.
REQ-014 Accepted start SHALL, on the same edge: rk[0]<=cipher_key, gk_key_in<=cipher_key, gk_round<=0, cnt<=0, busy<=1, done<=0, go to WAIT.
REQ-015 In WAIT, gk_key_in and gk_round SHALL be held stable and cnt SHALL increment each cycle while cnt<GK_LATENCY.
REQ-016 On the WAIT edge with cnt==GK_LATENCY and gk_round==i: rk[i+1]<=gk_key_out, gk_key_in<=gk_key_out, gk_round<=i+1, cnt<=0.
REQ-017 On the capture edge with gk_round==9: SHALL store rk[10], then busy<=0, done<=1, gk_round<=0, go to DONE.
REQ-018 Each round SHALL take GK_LATENCY+1 cycles; done SHALL rise exactly 10*(GK_LATENCY+1) edges after the accepted start edge (30 at default).
REQ-019 start while busy SHALL be ignored with no effect on the sequence.
REQ-020 Read latency SHALL be 1 cycle: rd_key<=rk[rd_addr] each edge; rd_addr 11..15 SHALL return 128'h0.
REQ-021 Reads during busy SHALL be permitted and return current store contents, including not-yet-rewritten entries from a previous expansion.
REQ-022 start in DONE SHALL restart expansion, overwriting rk[0..10] progressively.
REQ-023 cnt SHALL be wide enough for GK_LATENCY up to 15 without wrap.

Reset
REQ-024 rst high SHALL, on the next edge, force IDLE and busy=0, done=0, gk_round=0, gk_key_in=0, rd_key=0, cnt=0, and clear rk[0..10] to zero.
REQ-025 rst SHALL take priority over start and over any in-progress round; reset mid-expansion SHALL abandon it with no partial done.

Configuration
REQ-026 Macro KEY_ZEROIZE_EN, when defined, SHALL add input zeroize (1 bit); when zeroize is high, the next edge SHALL clear rk[0..10], gk_key_in and rd_key to zero, deassert busy and done, and enter IDLE, with priority over start but below rst.
REQ-027 Without KEY_ZEROIZE_EN the zeroize port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-028 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse, with gen_key attached -> done high 30 cycles later; rd_addr=1 gives a0fafe1788542cb123a339392a6c7605; rd_addr=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-029 Same run: monitor gk_round -> steps 0..9, each value held exactly 3 cycles; busy high 30 cycles.
REQ-030 start pulse at cycle 12 of an expansion -> ignored; rd_addr=10 still gives d014f9a8c9ee2589e13f0cc8b6630ca6 at done.
REQ-031 rst asserted at cycle 15 of an expansion -> next cycle busy=0, done=0; rd_addr=0..10 all read 0; a new start then completes normally in 30 cycles.
REQ-032 rd_addr=11 and rd_addr=15 after done -> rd_key=0; rd_addr=0 -> cipher_key one cycle after the address is applied.
REQ-033 With KEY_ZEROIZE_EN: zeroize pulse in DONE -> next cycle done=0 and all rk read 0; zeroize with simultaneous start -> stays IDLE.
